// File: rtl/i2c_target_pkg.sv
`default_nettype none
// ============================================================================
// i2c_target_pkg : shared types and constants for the I2C target core
// Rev 1.0
// ============================================================================
package i2c_target_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      A_ACK     = 3'd2,
      WR_DATA   = 3'd3,
      WR_ACK    = 3'd4,
      RD_DATA   = 3'd5,
      RD_ACK    = 3'd6,
      WAIT_STOP = 3'd7
   } state_t;

   localparam logic [4:0] REG_STATUS = 5'd0;
   localparam logic [4:0] REG_CTRL   = 5'd1;
   localparam logic [4:0] REG_TX     = 5'd2;
   localparam logic [4:0] REG_CLR    = 5'd3;

   localparam int ST_RX_VALID  = 8;
   localparam int ST_TX_FULL   = 9;
   localparam int ST_BUSY      = 10;
   localparam int ST_OVERFLOW  = 11;
   localparam int ST_UNDERRUN  = 12;
   localparam int ST_LAST_NACK = 13;

endpackage
`default_nettype wire

// File: rtl/i2c_target_core_if.sv
`default_nettype none
// ============================================================================
// i2c_target_core_if : CPU slot bus between the host and the I2C target core
// Rev 1.0
// ============================================================================
interface i2c_target_core_if;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  reg_addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;

   modport master (output cs, read, write, reg_addr, wr_data, input rd_data);
   modport slave  (input cs, read, write, reg_addr, wr_data, output rd_data);
endinterface
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// i2c_bus_sync : SCL/SDA synchronisers with edge and START/STOP detection
// Rev 1.0
// ============================================================================
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);
   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_prev;
   logic                   sda_prev;
   logic                   scl_s;

   // Flops reset to the idle-bus level so no phantom edges follow reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev;
   assign scl_fall  = ~scl_s & scl_prev;
   assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_target_core.sv
`default_nettype none
// ============================================================================
// i2c_target_core : memory-mapped I2C target with one programmable address
// Rev 1.0
// ============================================================================
module i2c_target_core
   import i2c_target_pkg::*;
#(
   parameter int         SYNC_STAGES  = 2,
   parameter logic [6:0] DEFAULT_ADDR = 7'h42
) (
   input  logic              clk,
   input  logic              reset,
   i2c_target_core_if.slave  bus,
   inout  wire               scl,
   inout  wire               sda
);
   state_t     state;
   logic [2:0] bit_cnt;
   logic [7:0] shift_reg;
   logic       phase;
   logic       rw;
   logic       ack_wr;
   logic       sda_oe;
   logic [6:0] own_addr;
   logic       enable;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic [7:0] tx_byte;
   logic       tx_full;
   logic       tx_fresh;
   logic       rd_from_tx;
   logic       overflow;
   logic       underrun;
   logic       last_nack;

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;
   logic [7:0] w_byte;
   logic [7:0] w_src;
   logic       w_ctrl_wr, w_tx_wr, w_clr_wr, w_busy;
   logic       unused_bits;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .reset     (reset),
      .scl       (scl),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   assign scl = 1'bz;
   assign sda = sda_oe ? 1'b0 : 1'bz;

   assign w_byte    = {shift_reg[6:0], sda_s};
   assign w_src     = tx_full ? tx_byte : 8'hFF;
   assign w_ctrl_wr = bus.cs & bus.write & (bus.reg_addr == REG_CTRL);
   assign w_tx_wr   = bus.cs & bus.write & (bus.reg_addr == REG_TX);
   assign w_clr_wr  = bus.cs & bus.write & (bus.reg_addr == REG_CLR);
   assign w_busy    = (state != IDLE);
   assign unused_bits = &{1'b0, bus.read, bus.wr_data[31:8]};

   always_comb begin
      bus.rd_data = '0;
      case (bus.reg_addr)
         REG_STATUS: begin
            bus.rd_data[7:0]          = rx_byte;
            bus.rd_data[ST_RX_VALID]  = rx_valid;
            bus.rd_data[ST_TX_FULL]   = tx_full;
            bus.rd_data[ST_BUSY]      = w_busy;
            bus.rd_data[ST_OVERFLOW]  = overflow;
            bus.rd_data[ST_UNDERRUN]  = underrun;
            bus.rd_data[ST_LAST_NACK] = last_nack;
         end
         REG_CTRL: bus.rd_data[7:0] = {enable, own_addr};
         default: ;
      endcase
   end

   // CPU writes come first so that bus-side updates in the same cycle win.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         shift_reg  <= 8'd0;
         phase      <= 1'b0;
         rw         <= 1'b0;
         ack_wr     <= 1'b0;
         sda_oe     <= 1'b0;
         own_addr   <= DEFAULT_ADDR;
         enable     <= 1'b0;
         rx_byte    <= 8'd0;
         rx_valid   <= 1'b0;
         tx_byte    <= 8'd0;
         tx_full    <= 1'b0;
         tx_fresh   <= 1'b0;
         rd_from_tx <= 1'b0;
         overflow   <= 1'b0;
         underrun   <= 1'b0;
         last_nack  <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            own_addr <= bus.wr_data[6:0];
            enable   <= bus.wr_data[7];
         end
         if (w_tx_wr) begin
            tx_byte  <= bus.wr_data[7:0];
            tx_full  <= 1'b1;
            tx_fresh <= 1'b1;
         end
         if (w_clr_wr) begin
            rx_valid <= 1'b0;
            overflow <= 1'b0;
            underrun <= 1'b0;
         end

         if (!enable || stop_det) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
         end else if (start_det) begin
            state   <= ADDR;
            bit_cnt <= 3'd0;
            phase   <= 1'b0;
            sda_oe  <= 1'b0;
         end else begin
            case (state)
               ADDR: if (scl_rise) begin
                  shift_reg <= w_byte;
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     phase <= 1'b0;
                     rw    <= w_byte[0];
                     state <= (w_byte[7:1] == own_addr) ? A_ACK : IDLE;
                  end
               end
               A_ACK: if (scl_fall) begin
                  if (!phase) begin
                     sda_oe <= 1'b1;
                     phase  <= 1'b1;
                  end else begin
                     phase   <= 1'b0;
                     bit_cnt <= 3'd0;
                     if (rw) begin
                        shift_reg  <= w_src;
                        sda_oe     <= ~w_src[7];
                        rd_from_tx <= tx_full;
                        tx_fresh   <= w_tx_wr;
                        if (!tx_full) underrun <= 1'b1;
                        state <= RD_DATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= WR_DATA;
                     end
                  end
               end
               WR_DATA: if (scl_rise) begin
                  shift_reg <= w_byte;
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     phase <= 1'b0;
                     state <= WR_ACK;
                     if (!rx_valid) begin
                        rx_byte  <= w_byte;
                        rx_valid <= 1'b1;
                        ack_wr   <= 1'b1;
                     end else begin
                        overflow <= 1'b1;
                        ack_wr   <= 1'b0;
                     end
                  end
               end
               WR_ACK: if (scl_fall) begin
                  if (!phase) begin
                     sda_oe <= ack_wr;
                     phase  <= 1'b1;
                  end else begin
                     sda_oe  <= 1'b0;
                     phase   <= 1'b0;
                     bit_cnt <= 3'd0;
                     state   <= WR_DATA;
                  end
               end
               RD_DATA: if (scl_fall) begin
                  if (bit_cnt == 3'd7) begin
                     sda_oe <= 1'b0;
                     phase  <= 1'b0;
                     state  <= RD_ACK;
                     // A TX reload during this byte belongs to the next one.
                     if (rd_from_tx && !tx_fresh && !w_tx_wr) tx_full <= 1'b0;
                  end else begin
                     bit_cnt   <= bit_cnt + 3'd1;
                     shift_reg <= {shift_reg[6:0], 1'b0};
                     sda_oe    <= ~shift_reg[6];
                  end
               end
               RD_ACK: if (scl_rise) begin
                  last_nack <= sda_s;
                  if (sda_s) state <= WAIT_STOP;
                  else       phase <= 1'b1;
               end else if (scl_fall && phase) begin
                  phase      <= 1'b0;
                  bit_cnt    <= 3'd0;
                  shift_reg  <= w_src;
                  sda_oe     <= ~w_src[7];
                  rd_from_tx <= tx_full;
                  tx_fresh   <= w_tx_wr;
                  if (!tx_full) underrun <= 1'b1;
                  state <= RD_DATA;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_core.sv
`default_nettype none
// ============================================================================
// tb_i2c_target_core : bit-banged I2C master bench with scoreboard checking
// Rev 1.0
// ============================================================================
module tb_i2c_target_core;
   import i2c_target_pkg::*;

   localparam int Q = 10;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic m_scl = 1'b1;
   logic m_sda = 1'b1;
   wire  scl;
   wire  sda;

   assign scl = m_scl ? 1'bz : 1'b0;
   assign sda = m_sda ? 1'bz : 1'b0;
   pullup pu_scl (scl);
   pullup pu_sda (sda);

   i2c_target_core_if bus ();

   i2c_target_core #(.SYNC_STAGES(2), .DEFAULT_ADDR(7'h42)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .scl   (scl),
      .sda   (sda)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string      name;
      logic [7:0] val;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      string       name;
      logic [7:0]  ctrl;
      bit          clr;
      logic [7:0]  addr;
      logic [7:0]  data;
      bit          aack;
      bit          dack;
      logic [13:0] status;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sb_push(input string name, input logic [7:0] v);
      sb.push_back('{name, v});
   endtask

   task automatic sb_pop(input logic [7:0] act);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_underflow: got 0x%0h, expected nothing queued", act);
      end else begin
         e = sb.pop_front();
         check(e.name, {24'd0, act}, {24'd0, e.val});
      end
   endtask

   task automatic qwait();
      repeat (Q) @(negedge clk);
   endtask

   task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.cs = 1'b1; bus.write = 1'b1; bus.reg_addr = a; bus.wr_data = d;
      @(negedge clk);
      bus.cs = 1'b0; bus.write = 1'b0;
   endtask

   task automatic cpu_read(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.cs = 1'b1; bus.read = 1'b1; bus.reg_addr = a;
      #1 d = bus.rd_data;
      @(negedge clk);
      bus.cs = 1'b0; bus.read = 1'b0;
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; m_scl = 1'b1; qwait();
      m_sda = 1'b0; qwait();
      m_scl = 1'b0; qwait();
   endtask

   task automatic i2c_rstart();
      m_sda = 1'b1; qwait();
      m_scl = 1'b1; qwait();
      m_sda = 1'b0; qwait();
      m_scl = 1'b0; qwait();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; qwait();
      m_scl = 1'b1; qwait();
      m_sda = 1'b1; qwait();
      qwait();
   endtask

   task automatic write_bit(input logic b);
      m_sda = b; qwait();
      m_scl = 1'b1; qwait(); qwait();
      m_scl = 1'b0; qwait();
   endtask

   task automatic read_bit(output logic b);
      m_sda = 1'b1; qwait();
      m_scl = 1'b1; qwait();
      b = sda; qwait();
      m_scl = 1'b0; qwait();
   endtask

   task automatic send_byte(input logic [7:0] v, output logic ack);
      logic nb;
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(nb);
      ack = ~nb;
   endtask

   task automatic recv_byte(input logic give_ack, output logic [7:0] v);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         v[i] = b;
      end
      write_bit(~give_ack);
   endtask

   initial begin
      logic [31:0] d;
      logic        ack;
      logic [7:0]  rb;

      vecs[0] = '{"wr_match",    8'hC2, 1'b1, 8'h84, 8'h5A, 1'b1, 1'b1, 14'h015A};
      vecs[1] = '{"wr_mismatch", 8'hC2, 1'b1, 8'h86, 8'h33, 1'b0, 1'b0, 14'h005A};
      vecs[2] = '{"ovf_first",   8'hC2, 1'b1, 8'h84, 8'h11, 1'b1, 1'b1, 14'h0111};
      vecs[3] = '{"ovf_second",  8'hC2, 1'b0, 8'h84, 8'h22, 1'b1, 1'b0, 14'h0911};
      vecs[4] = '{"disabled",    8'h42, 1'b1, 8'h84, 8'h99, 1'b0, 1'b0, 14'h0011};
      vecs[5] = '{"new_addr",    8'h95, 1'b1, 8'h2A, 8'hE7, 1'b1, 1'b1, 14'h01E7};

      bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.reg_addr = 5'd0; bus.wr_data = 32'd0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      cpu_read(REG_STATUS, d); check("rst_status", d, 32'h0);
      cpu_read(REG_CTRL, d);   check("rst_ctrl", d, 32'h42);
      cpu_read(5'd7, d);       check("unmapped_read", d, 32'h0);
      check("rst_sda", {31'd0, sda}, 32'd1);

      foreach (vecs[i]) begin
         cpu_write(REG_CTRL, {24'd0, vecs[i].ctrl});
         if (vecs[i].clr) cpu_write(REG_CLR, 32'd0);
         cpu_read(REG_CTRL, d);
         check({vecs[i].name, "/ctrl"}, d, {24'd0, vecs[i].ctrl});
         i2c_start();
         sb_push({vecs[i].name, "/addr_ack"}, {7'd0, vecs[i].aack});
         send_byte(vecs[i].addr, ack);
         sb_pop({7'd0, ack});
         cpu_read(REG_STATUS, d);
         check({vecs[i].name, "/busy"}, {31'd0, d[ST_BUSY]}, {31'd0, vecs[i].aack});
         if (vecs[i].aack) begin
            sb_push({vecs[i].name, "/data_ack"}, {7'd0, vecs[i].dack});
            send_byte(vecs[i].data, ack);
            sb_pop({7'd0, ack});
         end
         i2c_stop();
         cpu_read(REG_STATUS, d);
         check({vecs[i].name, "/status"}, d, {18'd0, vecs[i].status});
      end

      // Read: first byte from TX, second underruns, master NACKs the second.
      cpu_write(REG_CTRL, 32'hC2);
      cpu_write(REG_CLR, 32'd0);
      cpu_write(REG_TX, 32'hC3);
      cpu_read(REG_STATUS, d);
      check("rd/tx_full", {31'd0, d[ST_TX_FULL]}, 32'd1);
      i2c_start();
      sb_push("rd/addr_ack", 8'd1); send_byte(8'h85, ack); sb_pop({7'd0, ack});
      sb_push("rd/byte0", 8'hC3);   recv_byte(1'b1, rb);   sb_pop(rb);
      sb_push("rd/byte1", 8'hFF);   recv_byte(1'b0, rb);   sb_pop(rb);
      cpu_read(REG_STATUS, d);
      check("rd/status_wait_stop", d, 32'h34E7);
      repeat (4) qwait();
      cpu_read(REG_STATUS, d);
      check("rd/still_busy", {31'd0, d[ST_BUSY]}, 32'd1);
      i2c_stop();
      cpu_read(REG_STATUS, d);
      check("rd/status_after_stop", d, 32'h30E7);

      // Write then repeated START into a read, no STOP in between.
      cpu_write(REG_CLR, 32'd0);
      cpu_write(REG_TX, 32'h3C);
      i2c_start();
      sb_push("sr/wr_addr_ack", 8'd1); send_byte(8'h84, ack); sb_pop({7'd0, ack});
      sb_push("sr/wr_data_ack", 8'd1); send_byte(8'h01, ack); sb_pop({7'd0, ack});
      i2c_rstart();
      sb_push("sr/rd_addr_ack", 8'd1); send_byte(8'h85, ack); sb_pop({7'd0, ack});
      sb_push("sr/rd_byte", 8'h3C);    recv_byte(1'b0, rb);   sb_pop(rb);
      i2c_stop();
      cpu_read(REG_STATUS, d);
      check("sr/status", d, 32'h2101);

      // Reset while the target is holding SDA low for a 0 data bit.
      cpu_write(REG_TX, 32'h00);
      i2c_start();
      sb_push("rst/addr_ack", 8'd1); send_byte(8'h85, ack); sb_pop({7'd0, ack});
      check("rst/sda_driven", {31'd0, sda}, 32'd0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      check("rst/sda_released", {31'd0, sda}, 32'd1);
      @(negedge clk); reset = 1'b0;
      m_scl = 1'b1; m_sda = 1'b1; qwait();
      cpu_read(REG_STATUS, d); check("rst/status", d, 32'h0);
      cpu_read(REG_CTRL, d);   check("rst/ctrl", d, 32'h42);

      check("sb_empty", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
